// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Stall/flush controller on the ID side of the ID/EX pipeline register.
// It compares the ID instruction's source registers with the fields that
// ID/EX presents to EX, and drives the PC, IF/ID and ID/EX enables for:
//   - load-use bubbles (load in EX, its result needed by ID)
//   - taken-branch flushes of IF/ID
//   - multi-cycle EX holds (MUL) lasting MUL_LAT cycles in EX
//
// Parameters:
//   MUL_LAT  EX occupancy of a multi-cycle op, 1..16 (1 = never hold)
//
// Ports:
//   clk_i              clock, rising edge
//   rst_i              asynchronous, active-low reset
//   start_i            pipeline run enable (level)
//   ID_rs1_i/ID_rs2_i  source register addresses of the ID instruction
//   ID_use_rs1_i/2_i   ID instruction actually reads rs1 / rs2
//   ID_branch_taken_i  branch in ID resolved taken
//   EX_MemRead_i       MemRead field at the ID/EX output
//   EX_RDaddr_i        RDaddr field at the ID/EX output
//   EX_mul_i           instruction in EX is multi-cycle
//   PCWrite_o          PC update enable
//   IFID_write_o       IF/ID write enable
//   IFID_flush_o       zero IF/ID instruction on next edge
//   IDEX_bubble_o      zero ID/EX control fields on next edge
//   EX_hold_o          freeze ID/EX and EX stage contents
//   stall_cnt_o        (STALL_COUNT_EN only) saturating count of cycles
//                      with the pipeline running and the PC frozen
//   dbg_st_o           current FSM state (0 IDLE, 1 RUN, 2 MUL_WAIT)
//   dbg_cnt_o          current hold down-counter value
//
// Optional feature macro: STALL_COUNT_EN (adds stall_cnt_o).
//
// All enables are combinational from state, counter and inputs, so a
// hazard is acted on in the same cycle it appears.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  ID_rs1_i,
    input  logic [4:0]  ID_rs2_i,
    input  logic        ID_use_rs1_i,
    input  logic        ID_use_rs2_i,
    input  logic        ID_branch_taken_i,
    input  logic        EX_MemRead_i,
    input  logic [4:0]  EX_RDaddr_i,
    input  logic        EX_mul_i,
    output logic        PCWrite_o,
    output logic        IFID_write_o,
    output logic        IFID_flush_o,
    output logic        IDEX_bubble_o,
    output logic        EX_hold_o,
`ifdef STALL_COUNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    output logic [1:0]  dbg_st_o,
    output logic [3:0]  dbg_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MUL_WAIT = 2'd2
    } st_t;

    // A hold only exists for ops that occupy EX for two or more cycles.
    localparam bit       HOLD_EN  = (MUL_LAT >= 2);
    // First hold cycle is spent in RUN, the rest in MUL_WAIT with cnt!=0,
    // and the cnt==0 cycle is the op's last EX cycle (no hold).
    localparam logic [3:0] CNT_LOAD = 4'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

    st_t        st, st_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic lu;
    logic run_pc, run_ifid_w, run_flush, run_bubble;

    // Load-use hazard; x0 is hard-wired zero and never a hazard.
    assign lu = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
                ((ID_use_rs1_i && (ID_rs1_i == EX_RDaddr_i)) ||
                 (ID_use_rs2_i && (ID_rs2_i == EX_RDaddr_i)));

    // Normal-run decisions (stall beats branch: the branch operand is the
    // load result, so it is re-evaluated once the load reaches MEM).
    always_comb begin
        run_pc     = 1'b1;
        run_ifid_w = 1'b1;
        run_flush  = 1'b0;
        run_bubble = 1'b0;
        if (lu) begin
            run_pc     = 1'b0;
            run_ifid_w = 1'b0;
            run_bubble = 1'b1;
        end else if (ID_branch_taken_i) begin
            run_flush  = 1'b1;
        end
    end

    always_comb begin
        PCWrite_o     = 1'b0;
        IFID_write_o  = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_bubble_o = 1'b1;
        EX_hold_o     = 1'b0;
        st_nxt        = st;
        cnt_nxt       = cnt;
        case (st)
            ST_IDLE: begin
                if (start_i) st_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (EX_mul_i && HOLD_EN) begin
                    IDEX_bubble_o = 1'b0;
                    EX_hold_o     = 1'b1;
                    cnt_nxt       = CNT_LOAD;
                    st_nxt        = ST_MUL_WAIT;
                end else if (!start_i) begin
                    st_nxt = ST_IDLE;
                end else begin
                    PCWrite_o     = run_pc;
                    IFID_write_o  = run_ifid_w;
                    IFID_flush_o  = run_flush;
                    IDEX_bubble_o = run_bubble;
                end
            end
            ST_MUL_WAIT: begin
                if (cnt != 4'd0) begin
                    IDEX_bubble_o = 1'b0;
                    EX_hold_o     = 1'b1;
                    cnt_nxt       = cnt - 4'd1;
                end else begin
                    // Release cycle: EX_mul_i still shows the same op, so
                    // it is ignored here to avoid retriggering the hold.
                    PCWrite_o     = run_pc;
                    IFID_write_o  = run_ifid_w;
                    IFID_flush_o  = run_flush;
                    IDEX_bubble_o = run_bubble;
                    st_nxt        = ST_RUN;
                end
            end
            default: begin
                st_nxt  = ST_IDLE;
                cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st  <= ST_IDLE;
            cnt <= 4'd0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

`ifdef STALL_COUNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= 32'd0;
        end else if ((st != ST_IDLE) && !PCWrite_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

    assign dbg_st_o  = st;
    assign dbg_cnt_o = cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Directed bench for hazard_stall_ctrl. Two instances share the inputs:
// dut (MUL_LAT=4) and dut1 (MUL_LAT=1, which must never hold).
// Outputs are packed as {PCWrite, IFID_write, IFID_flush, IDEX_bubble,
// EX_hold}. Inputs change 1 time unit after a rising edge, outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    // expected output patterns {pc, ifid_w, flush, bubble, hold}
    localparam logic [4:0] O_IDLE = 5'b00010;
    localparam logic [4:0] O_RUN  = 5'b11000;
    localparam logic [4:0] O_LU   = 5'b00010;
    localparam logic [4:0] O_BR   = 5'b11100;
    localparam logic [4:0] O_HOLD = 5'b00001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_MULW = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic       start_i;
    logic [4:0] ID_rs1_i, ID_rs2_i, EX_RDaddr_i;
    logic       ID_use_rs1_i, ID_use_rs2_i, ID_branch_taken_i;
    logic       EX_MemRead_i, EX_mul_i;

    logic       pcw, ifw, fl, bub, hld;
    logic       pcw1, ifw1, fl1, bub1, hld1;
    logic [1:0] st, st1;
    logic [3:0] cnt, cnt1;
`ifdef STALL_COUNT_EN
    logic [31:0] scnt, scnt1;
`endif

    logic [4:0] outs, outs1;
    assign outs  = {pcw, ifw, fl, bub, hld};
    assign outs1 = {pcw1, ifw1, fl1, bub1, hld1};

    hazard_stall_ctrl #(.MUL_LAT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
        .ID_use_rs1_i(ID_use_rs1_i), .ID_use_rs2_i(ID_use_rs2_i),
        .ID_branch_taken_i(ID_branch_taken_i),
        .EX_MemRead_i(EX_MemRead_i), .EX_RDaddr_i(EX_RDaddr_i),
        .EX_mul_i(EX_mul_i),
        .PCWrite_o(pcw), .IFID_write_o(ifw), .IFID_flush_o(fl),
        .IDEX_bubble_o(bub), .EX_hold_o(hld),
`ifdef STALL_COUNT_EN
        .stall_cnt_o(scnt),
`endif
        .dbg_st_o(st), .dbg_cnt_o(cnt)
    );

    hazard_stall_ctrl #(.MUL_LAT(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
        .ID_use_rs1_i(ID_use_rs1_i), .ID_use_rs2_i(ID_use_rs2_i),
        .ID_branch_taken_i(ID_branch_taken_i),
        .EX_MemRead_i(EX_MemRead_i), .EX_RDaddr_i(EX_RDaddr_i),
        .EX_mul_i(EX_mul_i),
        .PCWrite_o(pcw1), .IFID_write_o(ifw1), .IFID_flush_o(fl1),
        .IDEX_bubble_o(bub1), .EX_hold_o(hld1),
`ifdef STALL_COUNT_EN
        .stall_cnt_o(scnt1),
`endif
        .dbg_st_o(st1), .dbg_cnt_o(cnt1)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr_in();
        ID_rs1_i = 5'd0; ID_rs2_i = 5'd0; EX_RDaddr_i = 5'd0;
        ID_use_rs1_i = 1'b0; ID_use_rs2_i = 1'b0;
        ID_branch_taken_i = 1'b0; EX_MemRead_i = 1'b0; EX_mul_i = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
        EX_MemRead_i = 1'b1; EX_RDaddr_i = rd;
        ID_rs1_i = r1; ID_use_rs1_i = u1;
        ID_rs2_i = r2; ID_use_rs2_i = u2;
    endtask

    // sample dut outputs (and state) at the falling edge, then advance
    task automatic cyc(input string tag, input logic [4:0] exp_o, input logic [1:0] exp_st);
        @(negedge clk_i);
        check_val({tag, "_out"}, 32'(outs), 32'(exp_o));
        check_val({tag, "_st"}, 32'(st), 32'(exp_st));
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc1(input string tag, input logic [4:0] exp_o, input logic [1:0] exp_st,
                        input logic [3:0] exp_cnt, input logic exp_hold1);
        @(negedge clk_i);
        check_val({tag, "_out"}, 32'(outs), 32'(exp_o));
        check_val({tag, "_st"}, 32'(st), 32'(exp_st));
        check_val({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
        check_val({tag, "_lat1_hold"}, 32'(hld1), 32'(exp_hold1));
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i = 1'b0;
        start_i = 1'b0;
        clr_in();
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_out", 32'(outs), 32'(O_IDLE));
        check_val("rst_st", 32'(st), 32'(S_IDLE));
        check_val("rst_cnt", 32'(cnt), 32'd0);
        rst_i = 1'b1;

        cyc("idle_nostart", O_IDLE, S_IDLE);
        cyc("idle_nostart2", O_IDLE, S_IDLE);
        start_i = 1'b1;
        cyc("idle_start", O_IDLE, S_IDLE);
        cyc("run_first", O_RUN, S_RUN);

        // load-use via rs2, then released
        set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        cyc("lu_rs2", O_LU, S_RUN);
        clr_in();
        cyc("lu_rs2_after", O_RUN, S_RUN);
        // load-use via rs1
        set_lu(5'd7, 5'd7, 1'b1, 5'd2, 1'b1);
        cyc("lu_rs1", O_LU, S_RUN);
        // x0 destination never a hazard
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        cyc("lu_x0", O_RUN, S_RUN);
        // address matches but source unused
        set_lu(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
        cyc("lu_unused", O_RUN, S_RUN);
        // match but not a load
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        EX_MemRead_i = 1'b0;
        cyc("lu_noload", O_RUN, S_RUN);
        clr_in();

        // taken branch, then branch colliding with load-use
        ID_branch_taken_i = 1'b1;
        cyc("br_taken", O_BR, S_RUN);
        set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        cyc("br_lu", O_LU, S_RUN);
        EX_MemRead_i = 1'b0;
        cyc("br_retry", O_BR, S_RUN);
        clr_in();

        // MUL held in EX for 4 cycles: hold 0..2, release at 3
        EX_mul_i = 1'b1;
        cyc1("mul_c0", O_HOLD, S_RUN, 4'd0, 1'b0);
        set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);   // ignored while holding
        ID_branch_taken_i = 1'b1;
        cyc1("mul_c1", O_HOLD, S_MULW, 4'd2, 1'b0);
        cyc1("mul_c2", O_HOLD, S_MULW, 4'd1, 1'b0);
        clr_in();
        EX_mul_i = 1'b1;
        cyc1("mul_c3", O_RUN, S_MULW, 4'd0, 1'b0);
        EX_mul_i = 1'b0;
        cyc1("mul_after", O_RUN, S_RUN, 4'd0, 1'b0);

        // second MUL: release cycle sees a load-use
        EX_mul_i = 1'b1;
        cyc("mul2_c0", O_HOLD, S_RUN);
        cyc("mul2_c1", O_HOLD, S_MULW);
        cyc("mul2_c2", O_HOLD, S_MULW);
        set_lu(5'd4, 5'd0, 1'b0, 5'd4, 1'b1);
        cyc("mul2_rel_lu", O_LU, S_MULW);
        clr_in();
        // third MUL: release cycle sees a taken branch
        EX_mul_i = 1'b1;
        cyc("mul3_c0", O_HOLD, S_RUN);
        cyc("mul3_c1", O_HOLD, S_MULW);
        cyc("mul3_c2", O_HOLD, S_MULW);
        ID_branch_taken_i = 1'b1;
        cyc("mul3_rel_br", O_BR, S_MULW);
        clr_in();

        // start_i drop in RUN: IDLE outputs now, IDLE state next
        start_i = 1'b0;
        cyc("stop_run", O_IDLE, S_RUN);
        cyc("stop_idle", O_IDLE, S_IDLE);
        start_i = 1'b1;
        cyc("restart_idle", O_IDLE, S_IDLE);
        cyc("restart_run", O_RUN, S_RUN);

        // async reset in the middle of MUL_WAIT
        EX_mul_i = 1'b1;
        cyc("rmul_c0", O_HOLD, S_RUN);
        @(negedge clk_i);
        check_val("rmul_c1_hold", 32'(hld), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check_val("rmul_rst_out", 32'(outs), 32'(O_IDLE));
        check_val("rmul_rst_st", 32'(st), 32'(S_IDLE));
        check_val("rmul_rst_cnt", 32'(cnt), 32'd0);
        #1;
        rst_i = 1'b1;
        clr_in();
        @(posedge clk_i);
        #1;

        // stall counter: 3 hold cycles + 1 load-use stall
        cyc("sc_run", O_RUN, S_RUN);
        EX_mul_i = 1'b1;
        cyc("sc_c0", O_HOLD, S_RUN);
        cyc("sc_c1", O_HOLD, S_MULW);
        cyc("sc_c2", O_HOLD, S_MULW);
        cyc("sc_c3", O_RUN, S_MULW);
        EX_mul_i = 1'b0;
        set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
        cyc("sc_lu", O_LU, S_RUN);
        clr_in();
        cyc("sc_done", O_RUN, S_RUN);
`ifdef STALL_COUNT_EN
        // dut1: only the load-use cycle stalls
        check_val("stall_cnt", scnt, 32'd4);
        check_val("stall_cnt_lat1", scnt1, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Stall/flush controller on the ID side of the ID/EX pipeline register. It reads back the fields that ID/EX presents to EX (MemRead, RDaddr, multi-cycle-op flag) and compares them with the source registers of the instruction currently in ID. It drives the PC, IF/ID and ID/EX enables for three cases: load-use bubbles, taken-branch flushes, and multi-cycle EX holds (MUL). A small FSM and a down-counter handle the multi-cycle hold and pipeline start-up.

Parameters:
MUL_LAT, 4, EX-stage occupancy in cycles of a multi-cycle op; legal range 1..16; 1 disables holding.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  pipeline run enable (level)
ID_rs1_i  in  5  rs1 address of instruction in ID
ID_rs2_i  in  5  rs2 address of instruction in ID
ID_use_rs1_i  in  1  ID instruction reads rs1
ID_use_rs2_i  in  1  ID instruction reads rs2
ID_branch_taken_i  in  1  branch in ID resolved taken
EX_MemRead_i  in  1  MemRead output of ID/EX
EX_RDaddr_i  in  5  RDaddr output of ID/EX
EX_mul_i  in  1  instruction in EX is multi-cycle
PCWrite_o  out  1  PC update enable
IFID_write_o  out  1  IF/ID register write enable
IFID_flush_o  out  1  zero IF/ID instruction on next edge
IDEX_bubble_o  out  1  zero ID/EX control fields on next edge
EX_hold_o  out  1  freeze ID/EX and EX stage contents

Behaviour:
- State: st in {IDLE, RUN, MUL_WAIT}; cnt[3:0]. Reset (rst_i=0, async): st=IDLE, cnt=0. Reset mid-MUL_WAIT aborts the hold immediately.
- Outputs are combinational from st, cnt and the inputs. No extra latency is added to any hazard.
- Hazard term: lu = EX_MemRead_i & (EX_RDaddr_i != 0) & ((ID_use_rs1_i & ID_rs1_i == EX_RDaddr_i) | (ID_use_rs2_i & ID_rs2_i == EX_RDaddr_i)). Register x0 is never a hazard.
- IDLE: PCWrite=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0, EX_hold=0. Next state is RUN when start_i=1.
- RUN, priority order:
  1. EX_mul_i=1 and MUL_LAT>=2: EX_hold=1, PCWrite=0, IFID_write=0, bubble=0, flush=0. Load cnt=MUL_LAT-2 and go to MUL_WAIT.
  2. lu=1: PCWrite=0, IFID_write=0, IDEX_bubble=1. ID_branch_taken_i is ignored (its operand is not ready). flush=0.
  3. ID_branch_taken_i=1: PCWrite=1, IFID_write=1, IFID_flush=1, bubble=0.
  4. Otherwise all enables are 1; bubble, flush and hold are 0.
- MUL_WAIT with cnt!=0: same outputs as RUN case 1; cnt decrements. Inputs lu and branch are not evaluated.
- MUL_WAIT with cnt==0: release cycle. EX_mul_i is ignored so the same op does not retrigger. lu and branch are evaluated as in RUN cases 2-4. Next state is RUN.
- Resulting EX_hold_o timing: high for exactly MUL_LAT-1 consecutive cycles starting with the op's first EX cycle. The op leaves EX at the end of its MUL_LAT-th cycle. MUL_LAT=1 never holds.
- start_i falling in RUN or MUL_WAIT: any hold still in progress completes, then the FSM returns to IDLE at the next RUN evaluation. In RUN, start_i=0 overrides cases 2-4: outputs take IDLE values and the next state is IDLE.
- Simultaneous lu and branch: the stall wins. The branch is re-evaluated next cycle once the load is in MEM.

Optional Feature:
STALL_COUNT_EN:
- Defined: adds output stall_cnt_o [31:0], reset 0. It increments each cycle with st!=IDLE and PCWrite_o=0, and saturates at 0xFFFFFFFF.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset low, then high with start_i=0 -> PCWrite=0, IDEX_bubble=1. Raise start_i -> next cycle all enables 1.
- EX_MemRead=1, EX_RDaddr=5, ID_rs2=5, use_rs2=1 -> one cycle of PCWrite=0, IFID_write=0, bubble=1. Repeat with EX_RDaddr=0 -> no stall.
- ID_branch_taken=1 with no hazard -> IFID_flush=1, PCWrite=1. Same cycle with lu=1 -> flush=0, bubble=1.
- MUL_LAT=4, EX_mul_i held 1 for 4 cycles -> EX_hold=1 in cycles 0-2, 0 in cycle 3, no retrigger in cycle 3.
- MUL_LAT=1, EX_mul_i=1 -> EX_hold never asserts. With STALL_COUNT_EN, a 3-cycle hold plus one load-use stall -> stall_cnt_o=4.
- rst_i pulsed low during MUL_WAIT -> EX_hold drops in the same cycle, st=IDLE, cnt=0.
